// File: rtl/fp_mul_normalize_pack_if.sv
// Handshake and data bundle between the multiplier datapath and its final
// normalize/round/pack stage. The slave side is the pack stage.
interface fp_mul_normalize_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [47:0] mant_in;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_z;
    logic [2:0]  flags;

    modport master (
        output in_valid, sign_in, exp_in, mant_in, is_nan, is_inf, is_zero, out_ready,
        input  in_ready, out_valid, output_z, flags
    );

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, is_nan, is_inf, is_zero, out_ready,
        output in_ready, out_valid, output_z, flags
    );
endinterface

// File: rtl/fp_mul_normalize_pack.sv
// Final binary32 multiplier stage: iterative normalization of the 48-bit product,
// round-to-nearest-even, flush-to-zero and IEEE-754 packing.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high; valid holds its payload stable until that edge, ready never depends on valid.
module fp_mul_normalize_pack (
    input  logic                       clk,
    input  logic                       rst,
    fp_mul_normalize_pack_if.slave     bus,
    output logic [1:0]                 o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [47:0]        r_mant;
    logic               r_sticky;
    logic               r_out_valid;
    logic [31:0]        r_z;
    logic [2:0]         r_flags;

    logic               w_special;
    logic [31:0]        w_special_z;
    logic [22:0]        w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic [23:0]        w_frac_sum;
    logic signed [9:0]  w_carry;
    logic signed [9:0]  w_exp_fin;
    logic [31:0]        w_round_z;
    logic [2:0]         w_round_flags;

    assign bus.in_ready  = (r_state == S_IDLE) && rst;
    assign bus.out_valid = r_out_valid;
    assign bus.output_z  = r_z;
    assign bus.flags     = r_flags;
    assign o_dbg_state   = r_state;

    assign w_special = bus.is_nan | bus.is_inf | bus.is_zero;

    always_comb begin
        w_special_z = {bus.sign_in, 31'h0};
        if (bus.is_nan || (bus.is_inf && bus.is_zero)) begin
            w_special_z = 32'h7FC00000;
        end else if (bus.is_inf) begin
            w_special_z = {bus.sign_in, 8'hFF, 23'h0};
        end
    end

    // Rounding assumes the hidden bit already sits at mant[46].
    assign w_frac     = r_mant[45:23];
    assign w_guard    = r_mant[22];
    assign w_sticky   = (|r_mant[21:0]) | r_sticky;
    assign w_inc      = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {23'h0, w_inc};
    assign w_carry    = {9'h0, w_frac_sum[23]};
    assign w_exp_fin  = r_exp + w_carry;

    always_comb begin
        w_round_z     = {r_sign, w_exp_fin[7:0], w_frac_sum[22:0]};
        w_round_flags = {2'b00, w_guard | w_sticky};
        if (w_exp_fin >= 10'sd255) begin
            w_round_z     = {r_sign, 8'hFF, 23'h0};
            w_round_flags = 3'b101;
        end else if (w_exp_fin <= 10'sd0) begin
            w_round_z     = {r_sign, 31'h0};
            w_round_flags = {2'b01, (|r_mant) | r_sticky};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = w_special ? S_DONE : S_NORM;
            S_NORM: begin
                if (r_mant == 48'h0)                w_next = S_DONE;
                else if (r_mant[47] || r_mant[46]) w_next = S_ROUND;
            end
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (r_out_valid && bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_mant      <= 48'h0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_z         <= 32'h0;
            r_flags     <= 3'b000;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign   <= bus.sign_in;
                        r_exp    <= bus.exp_in;
                        r_mant   <= bus.mant_in;
                        r_sticky <= 1'b0;
                        if (w_special) begin
                            r_z     <= w_special_z;
                            r_flags <= 3'b000;
                        end
                    end
                end
                S_NORM: begin
                    if (r_mant == 48'h0) begin
                        r_z     <= {r_sign, 31'h0};
                        r_flags <= 3'b000;
                    end else if (r_mant[47]) begin
                        r_mant   <= r_mant >> 1;
                        r_exp    <= r_exp + 10'sd1;
                        r_sticky <= r_sticky | r_mant[0];
                    end else if (!r_mant[46]) begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 10'sd1;
                    end
                end
                S_ROUND: begin
                    r_z     <= w_round_z;
                    r_flags <= w_round_flags;
                end
                S_DONE: begin
                    // out_valid rises one cycle after entering DONE and clears on the handshake.
                    if (!r_out_valid)        r_out_valid <= 1'b1;
                    else if (bus.out_ready)  r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_normalize_pack.sv
// Self-checking bench for fp_mul_normalize_pack: directed vectors, specials,
// backpressure, mid-operation reset and randomized products against a value model.
module tb_fp_mul_normalize_pack;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_tests;
    int         n_fail;

    fp_mul_normalize_pack_if bus();

    fp_mul_normalize_pack dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        s;
        int          e;
        logic [47:0] m;
        logic [31:0] z;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    // Value model: locate the leading one, round the 24-bit significand with plain
    // integer remainder arithmetic, then apply overflow / flush-to-zero.
    task automatic ref_model(input logic s, input int e_in, input logic [47:0] m,
                             input logic nan, input logic inf, input logic zero,
                             output logic [31:0] z, output logic [2:0] f, output int lat);
        int p, e, sh;
        logic [63:0] mm, kept, rem, half;
        logic inexact;
        f = 3'b000;
        if (nan || (inf && zero)) begin
            z = 32'h7FC00000; lat = 1;
        end else if (inf) begin
            z = {s, 8'hFF, 23'h0}; lat = 1;
        end else if (zero) begin
            z = {s, 31'h0}; lat = 1;
        end else begin
            p = -1;
            for (int i = 0; i < 48; i++) if (m[i]) p = i;
            mm = {16'h0, m};
            e = e_in + p - 46;
            if (p > 23) begin
                sh = p - 23;
                kept = mm >> sh;
                rem = mm & ((64'd1 << sh) - 64'd1);
                half = 64'd1 << (sh - 1);
            end else begin
                kept = mm << (23 - p);
                rem = 64'd0;
                half = 64'd1;
            end
            inexact = (rem != 64'd0);
            if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                z = {s, 8'hFF, 23'h0}; f = 3'b101;
            end else if (e <= 0) begin
                z = {s, 31'h0}; f = 3'b011;
            end else begin
                z = {s, 8'(e), kept[22:0]}; f = {2'b00, inexact};
            end
            lat = (p >= 46) ? 3 : 3 + (46 - p);
        end
    endtask

    // Presents one operand, waits for acceptance, then counts edges until out_valid.
    task automatic start_and_wait(input logic s, input int e, input logic [47:0] m,
                                  input logic nan, input logic inf, input logic zero,
                                  output logic [31:0] z, output logic [2:0] f, output int lat);
        int guard_cnt;
        @(negedge clk);
        bus.sign_in  = s;
        bus.exp_in   = 10'(e);
        bus.mant_in  = m;
        bus.is_nan   = nan;
        bus.is_inf   = inf;
        bus.is_zero  = zero;
        bus.in_valid = 1'b1;
        guard_cnt = 0;
        while (!bus.in_ready && guard_cnt < 100) begin
            @(negedge clk);
            guard_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        z = bus.output_z;
        f = bus.flags;
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.output_z !== 32'h0 || bus.flags !== 3'b000 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b z=%h flags=%b ready=%b, required 0 0 0 0",
                     bus.out_valid, bus.output_z, bus.flags, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b state=%0d, required 1 0", bus.in_ready, dbg_state);
        end
    endtask

    task automatic test_directed();
        vec_t v[11];
        logic [31:0] z;
        logic [2:0] f;
        int lat;
        v[0]  = '{1'b0, 128, 48'h6000_0000_0000, 32'h40400000, 3'b000, 3};
        v[1]  = '{1'b0, 127, 48'h9000_0000_0000, 32'h40100000, 3'b000, 3};
        v[2]  = '{1'b0, 127, 48'h4000_0040_0000, 32'h3F800000, 3'b001, 3};
        v[3]  = '{1'b0, 127, 48'h4000_00C0_0000, 32'h3F800002, 3'b001, 3};
        v[4]  = '{1'b0, 127, 48'h7FFF_FFC0_0000, 32'h40000000, 3'b001, 3};
        v[5]  = '{1'b0, 300, 48'h4000_0000_0000, 32'h7F800000, 3'b101, 3};
        v[6]  = '{1'b0, -5,  48'h4000_0000_0000, 32'h00000000, 3'b011, 3};
        v[7]  = '{1'b1, 300, 48'h4000_0000_0000, 32'hFF800000, 3'b101, 3};
        v[8]  = '{1'b1, -5,  48'h4000_0000_0000, 32'h80000000, 3'b011, 3};
        v[9]  = '{1'b1, 128, 48'h6000_0000_0000, 32'hC0400000, 3'b000, 3};
        v[10] = '{1'b0, 200, 48'h0000_0000_0001, 32'h4D000000, 3'b000, 49};
        foreach (v[i]) begin
            start_and_wait(v[i].s, v[i].e, v[i].m, 1'b0, 1'b0, 1'b0, z, f, lat);
            n_tests++;
            if (z !== v[i].z || f !== v[i].f || lat !== v[i].lat) begin
                n_fail++;
                $display("FAIL directed[%0d]: z=%h flags=%b lat=%0d, required z=%h flags=%b lat=%0d",
                         i, z, f, lat, v[i].z, v[i].f, v[i].lat);
            end
            finish_op();
        end
    endtask

    task automatic test_specials();
        logic [3:0] cases [5];
        logic [31:0] z, ez;
        logic [2:0] f, ef;
        int lat, elat;
        cases[0] = 4'b0011;
        cases[1] = 4'b1100;
        cases[2] = 4'b1010;
        cases[3] = 4'b1001;
        cases[4] = 4'b0010;
        foreach (cases[i]) begin
            logic [47:0] m;
            m = {$urandom, $urandom};
            ref_model(cases[i][3], 130, m, cases[i][2], cases[i][1], cases[i][0], ez, ef, elat);
            start_and_wait(cases[i][3], 130, m, cases[i][2], cases[i][1], cases[i][0], z, f, lat);
            n_tests++;
            if (z !== ez || f !== ef || lat !== elat) begin
                n_fail++;
                $display("FAIL special[%0d]: z=%h flags=%b lat=%0d, required z=%h flags=%b lat=%0d",
                         i, z, f, lat, ez, ef, elat);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] z;
        logic [2:0] f;
        int lat, bad;
        start_and_wait(1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, z, f, lat);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.output_z !== 32'h3F800002 || bus.flags !== 3'b001) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad);
        end
        finish_op();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_norm();
        int seen;
        @(negedge clk);
        bus.sign_in = 1'b0; bus.exp_in = 10'd200; bus.mant_in = 48'h1;
        bus.is_nan = 1'b0; bus.is_inf = 1'b0; bus.is_zero = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_norm_state: state=%0d, required 1", dbg_state);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_norm_reset: valid=%b ready=%b, required 0 0", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_norm_release: ready=%b, required 1", bus.in_ready);
        end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_norm_aborted: out_valid seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] z, ez;
        logic [2:0] f, ef;
        int lat, elat, e, w;
        logic [63:0] r;
        logic [47:0] m;
        for (int n = 0; n < 40; n++) begin
            e = int'($urandom_range(0, 510)) - 127;
            if (n % 2 == 0) begin
                r = {40'h1, $urandom_range(0, 24'hFFFFFF) | 24'h800000} *
                    {40'h0, $urandom_range(0, 24'hFFFFFF) | 24'h800000};
                r = {16'h0, 24'($urandom_range(0, 24'hFFFFFF) | 24'h800000)} *
                    {40'h0, 24'($urandom_range(0, 24'hFFFFFF) | 24'h800000)};
            end else begin
                w = int'($urandom_range(1, 46));
                r = {$urandom, $urandom} & ((64'd1 << w) - 64'd1);
                r = r | (64'd1 << (w - 1));
            end
            m = r[47:0];
            ref_model(n[0], e, m, 1'b0, 1'b0, 1'b0, ez, ef, elat);
            start_and_wait(n[0], e, m, 1'b0, 1'b0, 1'b0, z, f, lat);
            n_tests++;
            if (z !== ez || f !== ef || lat !== elat) begin
                n_fail++;
                $display("FAIL random[%0d]: e=%0d m=%h z=%h flags=%b lat=%0d, required z=%h flags=%b lat=%0d",
                         n, e, m, z, f, lat, ez, ef, elat);
            end
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] z;
        logic [2:0] f;
        int lat;
        start_and_wait(1'b0, 128, 48'h6000_0000_0000, 1'b0, 1'b0, 1'b0, z, f, lat);
        finish_op();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        start_and_wait(1'b1, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, z, f, lat);
        n_tests++;
        if (z !== 32'hC0100000 || f !== 3'b000 || lat !== 3) begin
            n_fail++;
            $display("FAIL b2b_second: z=%h flags=%b lat=%0d, required z=c0100000 flags=000 lat=3", z, f, lat);
        end
        finish_op();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.sign_in = 1'b0;
        bus.exp_in = 10'h0;
        bus.mant_in = 48'h0;
        bus.is_nan = 1'b0;
        bus.is_inf = 1'b0;
        bus.is_zero = 1'b0;
        test_reset();
        test_directed();
        test_specials();
        test_backpressure();
        test_reset_mid_norm();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_normalize_pack.md
# fp_mul_normalize_pack

Final stage of the single-precision floating-point multiplier. It sits directly downstream of the unpack / exponent-add / mantissa-multiply stages. It accepts the sign, the rebiased exponent sum (exponent_a + exponent_b - 127), the raw 48-bit significand product and special-case flags. It normalizes the product iteratively, rounds to nearest-even, flushes subnormal results to zero, and packs the IEEE-754 word behind a valid/ready handshake.

## Interface
- No parameters; the format is fixed at IEEE-754 binary32.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  block can accept; high only in IDLE.
- sign_in  in  1  sign_a XOR sign_b.
- exp_in  in  10  signed two's-complement biased exponent sum, range -127..383.
- mant_in  in  48  product {hidden_a, fraction_a} * {hidden_b, fraction_b}; hidden bit is 0 for zero/subnormal operands.
- is_nan  in  1  either operand is NaN.
- is_inf  in  1  either operand is infinity.
- is_zero  in  1  either operand is zero.
- out_valid  out  1  output_z and flags valid.
- out_ready  in  1  downstream accepts.
- output_z  out  32  packed result {sign, exponent[7:0], fraction[22:0]}.
- flags  out  3  [2] overflow, [1] underflow, [0] inexact.

## Operation
**States:** IDLE, NORM, ROUND, DONE. All operands are captured into internal registers on acceptance.

**IDLE**
- Accept on in_valid && in_ready.
- If any of is_nan, is_inf or is_zero is set, go to DONE with the special result. Otherwise go to NORM.

**Special results** (priority top-down)
- is_nan, or is_inf && is_zero -> 32'h7FC00000, flags 0.
- is_inf -> {sign_in, 8'hFF, 23'h0}.
- is_zero -> {sign_in, 31'h0}.

**NORM** (one action per cycle)
- mant == 0 -> DONE with signed zero, flags 0.
- mant[47] == 1 -> shift right 1, exp + 1; sticky_extra |= dropped bit[0]; go to ROUND.
- mant[46] == 1 -> go to ROUND.
- Otherwise -> shift left 1, exp - 1; stay in NORM. At most 46 left shifts.

**ROUND** (single cycle, RNE)
- Fraction is mant[45:23]; guard is mant[22]; sticky is |mant[21:0] | sticky_extra.
- Increment the fraction when guard && (sticky || fraction[0]).
- A fraction carry-out sets fraction = 0 and exp + 1.
- inexact = guard | sticky.
- Final exp >= 255 -> {sign, 8'hFF, 0}, overflow = 1, inexact = 1.
- Final exp <= 0 -> {sign, 31'h0}, underflow = 1; inexact = 1 if any nonzero bits were discarded (flush-to-zero, no subnormal output).
- Otherwise -> {sign, exp[7:0], fraction}.
- Go to DONE.

**DONE**
- out_valid = 1; output_z and flags are held stable.
- On out_ready -> IDLE.

## Timing
- Reset (rst low, asynchronous): state = IDLE, out_valid = 0, output_z = 0, flags = 0, all internal registers = 0.
- While rst is low, in_valid is ignored.
- Reset mid-operation aborts the operation; no output is produced for the aborted operand.
- in_ready = (state == IDLE) && rst. It is combinational from state, with no dependence on in_valid.
- Accept at edge T:
  - Special operands: out_valid high after edge T+1.
  - Normalized or right-shift products: out_valid high after edge T+3.
  - k left shifts: out_valid high after edge T+3+k.
- Backpressure: DONE persists while out_ready = 0, and output_z and flags do not change. Handshake completes at the edge where out_valid && out_ready; out_valid drops after that edge.
- A new operand cannot be accepted in the same cycle as the output handshake (non-overlapped). The earliest next accept is one cycle later.
- Exponent arithmetic is 10-bit signed throughout; no wrap occurs for the input range plus 46 left shifts plus 2 increments.

## Test plan
- 1.5 x 2.0: exp_in=128, mant_in=48'h6000_0000_0000 -> output_z=32'h40400000, flags=0, out_valid 3 cycles after accept.
- 1.5 x 1.5 (right-shift path): exp_in=127, mant_in=48'h9000_0000_0000 -> 32'h40100000, flags=0.
- Rounding:
  - exp_in=127, mant_in=48'h4000_0040_0000 (tie, even) -> 32'h3F800000, inexact.
  - mant_in=48'h4000_00C0_0000 (tie, odd) -> 32'h3F800002.
  - mant_in=48'h7FFF_FFC0_0000 (carry-out) -> 32'h40000000.
- Range limits:
  - exp_in=300, mant_in=48'h4000_0000_0000 -> 32'h7F800000, flags=3'b101.
  - exp_in=-5, same mant_in -> 32'h00000000, underflow set.
  - sign_in=1 on either -> sign bit set.
- Left-shift path: exp_in=200, mant_in=48'h1 -> 46 NORM shifts, 32'h4D000000, out_valid 49 cycles after accept.
- Specials, control and handshake:
  - is_inf && is_zero -> 32'h7FC00000 after 1 cycle.
  - Hold out_ready=0 for 5 cycles -> output stable and in_ready=0.
  - Assert rst low mid-NORM -> out_valid=0 immediately, in_ready=1 once rst is released.
